inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage sitting directly upstream of the main decoder (`controll`). Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Presents the fetched instruction, with its opcode and func fields split out, to the decoder. Applies jump, branch and halt decisions returned for the issued instruction to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_b`  input  1: reset, asynchronous, active-low.
- `imem_req`  output  1: fetch request, held high until acknowledged.
- `imem_addr`  output  32: word-aligned fetch address, equal to `pc` while `imem_req` is high.
- `imem_ack`  input  1: memory has `imem_data` valid this cycle; sampled only when `imem_req` is high.
- `imem_data`  input  32: instruction word.
- `stall`  input  1: downstream not ready; freezes the issued instruction.
- `jump`  input  1: decoder says the issued instruction is J/JAL.
- `branch`  input  1: decoder says the issued instruction is a conditional branch.
- `branch_taken`  input  1: branch condition result from the ALU for the issued instruction.
- `halted`  input  1: decoder saw syscall; fetch stops permanently.
- `inst_valid`  output  1: `inst` holds a live instruction.
- `inst`  output  32: issued instruction word.
- `opcode`  output  6: `inst[31:26]`.
- `func`  output  6: `inst[5:0]`.
- `pc`  output  32: address of the current or issued instruction.
- `pc_plus4`  output  32: `pc + 4`, modulo 2^32 (used as the JAL link value).
- `fetch_halted`  output  1: HALT state reached.

## Operation
- States:
  - RST: entered on reset.
  - FETCH: request outstanding.
  - ISSUE: instruction presented to the decoder.
  - HALT: terminal until reset.
- RST -> FETCH unconditionally on the first edge after reset is released.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ack`=1: latch `imem_data` into `inst`, set `inst_valid`=1, go to ISSUE.
  - `pc` does not change in FETCH.
- ISSUE with `stall`=1: hold everything, including `inst`, `pc` and `inst_valid`. Ignore `jump`, `branch` and `halted`.
- ISSUE with `stall`=0: evaluate in priority order.
  1. `halted`=1 -> HALT.
  2. `jump`=1 -> `pc` <= {`pc_plus4[31:28]`, `inst[25:0]`, 2'b00}.
  3. `branch`=1 and `branch_taken`=1 -> `pc` <= `pc_plus4` + ({{14{`inst[15]`}}, `inst[15:0]`, 2'b00}), 32-bit, carry discarded.
  4. Otherwise `pc` <= `pc_plus4`.
  - For cases 2–4: clear `inst_valid`, go to FETCH.
  - `branch`=1 with `branch_taken`=0 falls through to case 4.
  - `jump` and `branch` both high: `jump` wins.
- HALT: `imem_req`=0, `inst_valid`=0, `fetch_halted`=1; `pc` frozen at the syscall address.
- `imem_ack` arriving in RST, ISSUE or HALT is ignored.
- `pc` wraps from 32'hFFFF_FFFC to 0.
- Reset values:
  - `pc`=`RESET_PC`, `inst`=0, `inst_valid`=0, `imem_req`=0, `fetch_halted`=0.
  - `opcode`/`func`=0, `pc_plus4`=`RESET_PC`+4.

## Timing
- Reset takes effect immediately, including mid-FETCH. `imem_req` drops in the same cycle; a pending ack is lost and the word is refetched after reset.
- `imem_req` rises one cycle after `rst_b` deasserts.
- Same-cycle ack allowed: FETCH lasts at least 1 cycle. Latency from req to `inst_valid` = ack cycles + 1 edge.
- Minimum issue rate: one instruction per 2 cycles (FETCH, ISSUE).
- Redirect takes effect on the ISSUE exit edge; the next `imem_addr` is the target, with no wrong-path fetch.
- `opcode`, `func` and `pc_plus4` are combinational from registers; all other outputs are registered.

## Test plan
- Reset with `RESET_PC`=0, memory acking same cycle, no control inputs -> addresses 0, 4, 8 issued on alternate cycles, `inst_valid` pulsing 0/1.
- Memory acking after 3 wait cycles -> `imem_req` held high 4 cycles at a stable address; `inst` changes only on the ack edge.
- At pc=32'h0000_0040, `branch`=1, `branch_taken`=1, `inst[15:0]`=16'hFFFE -> next `imem_addr` = 32'h0000_003C. Repeat with `branch_taken`=0 -> 32'h0000_0044.
- At pc=32'h1000_0000, `jump`=1, `inst[25:0]`=26'h000_0010 -> next `imem_addr` = 32'h1000_0040. With `branch` also high, the jump target is still taken.
- `stall` held 5 cycles in ISSUE with `jump` and `halted` toggling -> `inst` and `pc` unchanged; on release only the then-present inputs act.
- `halted`=1 at pc=32'h0000_0010 -> `fetch_halted`=1 and `imem_req`=0 forever, `pc`=32'h0000_0010. `rst_b` pulse mid-FETCH -> `imem_req` drops asynchronously and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage in front of the main decoder.
// Holds the program counter, fetches one 32-bit word per instruction over a
// req/ack handshake, presents it to the decoder and redirects the PC from the
// decoder's jump/branch/halt verdict on the issued instruction.
//
// Ports:
//   clk, rst_b                 clock, async active-low reset
//   imem_req/addr/ack/data     instruction memory handshake
//   stall                      downstream not ready, freezes the issued word
//   jump, branch, branch_taken decoder/ALU verdict for the issued word
//   halted                     syscall seen, stop fetching until reset
//   inst_valid, inst           issued instruction
//   opcode, func               inst[31:26], inst[5:0]
//   pc, pc_plus4               current/issued address and its link value
//   fetch_halted               terminal HALT state reached
//
// state  | meaning
// -------+--------------------------------------------
// RST    | just out of reset, request not yet raised
// FETCH  | request outstanding at pc
// ISSUE  | inst presented to the decoder
// HALT   | fetch stopped until the next reset
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        halted,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_halted
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        halt_q, halt_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign pc_plus4_w    = pc_q + 32'd4;
    assign jump_target   = {pc_plus4_w[31:28], inst_q[25:0], 2'b00};
    assign branch_target = pc_plus4_w + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            halt_q  <= halt_d;
        end
    end

    // req/halt flags are computed alongside the state so they leave as
    // registers rather than as a decode of the state vector.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        req_d   = req_q;
        halt_d  = halt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (halted) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        if (jump)
                            pc_d = jump_target;
                        else if (branch && branch_taken)
                            pc_d = branch_target;
                        else
                            pc_d = pc_plus4_w;
                    end
                end
            end
            ST_HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign inst_valid   = valid_q;
    assign inst         = inst_q;
    assign opcode       = inst_q[31:26];
    assign func         = inst_q[5:0];
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign fetch_halted = halt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: walks reset, sequential fetch, wait states,
// branch/jump redirects, stall, reset mid-fetch, PC wrap and halt.
module tb_inst_fetch;

    logic        clk;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        jump;
    logic        branch;
    logic        branch_taken;
    logic        halted;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_halted;

    int nvec  = 0;
    int nfail = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .jump        (jump),
        .branch      (branch),
        .branch_taken(branch_taken),
        .halted      (halted),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .opcode      (opcode),
        .func        (func),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_halted(fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch at addr after 'waits' empty cycles; prev is the word
    // that must stay on inst until the ack edge.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                         input logic [31:0] prev, input int waits);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_inst", inst, prev);
            chk("wait_valid", 32'(inst_valid), 32'd0);
        end
        imem_ack  = 1'b1;
        imem_data = word;
        tick();
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        chk("issue_valid", 32'(inst_valid), 32'd1);
        chk("issue_inst", inst, word);
        chk("issue_req", 32'(imem_req), 32'd0);
        chk("issue_pc", pc, addr);
    endtask

    // Apply one ISSUE-exit verdict and check the redirected fetch address.
    task automatic go(input logic j, input logic b, input logic t, input logic [31:0] exp_pc);
        jump = j; branch = b; branch_taken = t;
        tick();
        jump = 1'b0; branch = 1'b0; branch_taken = 1'b0;
        chk("redir_pc", pc, exp_pc);
        chk("redir_addr", imem_addr, exp_pc);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_valid", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst_b = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
        stall = 1'b0; jump = 1'b0; branch = 1'b0; branch_taken = 1'b0; halted = 1'b0;
        repeat (2) tick();

        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_halted", 32'(fetch_halted), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_func", 32'(func), 32'd0);
        chk("rst_pc4", pc_plus4, 32'h4);

        rst_b = 1'b1;
        chk("rel_req_low", 32'(imem_req), 32'd0);
        tick();
        chk("rel_req_high", 32'(imem_req), 32'd1);

        // sequential fetch, same-cycle ack
        fetch(32'h0, 32'h2000_0001, 32'h0, 0);
        chk("op_split", 32'(opcode), 32'd8);
        chk("func_split", 32'(func), 32'd1);
        chk("pc4_0", pc_plus4, 32'h4);
        go(1'b0, 1'b0, 1'b0, 32'h4);
        fetch(32'h4, 32'h0000_0022, 32'h2000_0001, 0);
        go(1'b0, 1'b0, 1'b0, 32'h8);

        // three wait states; jump to 0x40
        fetch(32'h8, 32'h0800_0010, 32'h0000_0022, 3);
        go(1'b1, 1'b0, 1'b0, 32'h40);

        // branch taken backward, then not taken
        fetch(32'h40, 32'h1022_FFFE, 32'h0800_0010, 0);
        go(1'b0, 1'b1, 1'b1, 32'h3C);
        fetch(32'h3C, 32'h0800_0010, 32'h1022_FFFE, 0);
        go(1'b1, 1'b0, 1'b0, 32'h40);
        fetch(32'h40, 32'h1022_FFFE, 32'h0800_0010, 0);
        go(1'b0, 1'b1, 1'b0, 32'h44);

        // stall with jump/halted toggling underneath
        fetch(32'h44, 32'h0800_0020, 32'h1022_FFFE, 1);
        for (int i = 0; i < 5; i++) begin
            stall  = 1'b1;
            jump   = (i % 2 == 0);
            halted = (i % 2 == 1);
            tick();
            chk("stall_inst", inst, 32'h0800_0020);
            chk("stall_pc", pc, 32'h44);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0; jump = 1'b0; halted = 1'b0;
        go(1'b0, 1'b0, 1'b0, 32'h48);

        // climb to 0x1000_0000 via a far jump and a sequential step
        fetch(32'h48, 32'h0BFF_FFFF, 32'h0800_0020, 0);
        go(1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);
        fetch(32'h0FFF_FFFC, 32'h0, 32'h0BFF_FFFF, 0);
        chk("pc4_nibble", pc_plus4, 32'h1000_0000);
        go(1'b0, 1'b0, 1'b0, 32'h1000_0000);
        fetch(32'h1000_0000, 32'h0800_0010, 32'h0, 0);
        go(1'b1, 1'b1, 1'b1, 32'h1000_0040);

        // reset pulse mid-FETCH with an ack on the wire
        imem_ack  = 1'b1;
        imem_data = 32'hCAFE_F00D;
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("arst_inst_lost", inst, 32'h0);
        imem_ack = 1'b0;
        rst_b = 1'b1;
        chk("arst_rel_req", 32'(imem_req), 32'd0);
        tick();
        chk("arst_refetch_req", 32'(imem_req), 32'd1);
        chk("arst_refetch_addr", imem_addr, 32'h0);

        // PC wrap: branch back from 0 to 0xFFFF_FFFC, then step to 0
        fetch(32'h0, 32'h1000_FFFE, 32'h0, 0);
        go(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0, 32'h1000_FFFE, 0);
        chk("pc4_wrap", pc_plus4, 32'h0);
        go(1'b0, 1'b0, 1'b0, 32'h0);

        // halt at 0x10, halted beats a simultaneous jump
        fetch(32'h0, 32'h0800_0004, 32'h0, 0);
        go(1'b1, 1'b0, 1'b0, 32'h10);
        fetch(32'h10, 32'h0000_000C, 32'h0800_0004, 0);
        halted = 1'b1; jump = 1'b1;
        tick();
        halted = 1'b0; jump = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("halt_flag", 32'(fetch_halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(inst_valid), 32'd0);
            chk("halt_pc", pc, 32'h10);
            imem_ack = (i % 2 == 0);
            tick();
        end
        imem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
